// File: rtl/video_in_pkg.sv
// Shared types and constants for the video input capture path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package video_in_pkg;

  typedef enum logic [1:0] {
    SYNC,
    WAIT_FRAME,
    LINE,
    GAP
  } state_t;

  localparam int PIX_PER_WORD = 4;
  localparam int WORD_W       = 32;

endpackage

// File: rtl/video_edge_sampler.sv
// Registers the video bus into the clk domain and detects falling edges of clk_in.
// Latency: 1 clk from a clk_in fall to cap; sampled bus is aligned with cap.
// Backpressure: none; free-running sampler.
//
// Ports:
//   clk, nRST         system clock, async active-low reset
//   clk_in            video pixel clock, sampled as data
//   pixel_in, frame_valid, line_valid   raw video bus
//   pix_s, fv_s, lv_s registered copies of the bus
//   cap               one-clk strobe: previous clk_in sample 1, current sample 0
module video_edge_sampler (
  input  logic       clk,
  input  logic       nRST,
  input  logic       clk_in,
  input  logic [7:0] pixel_in,
  input  logic       frame_valid,
  input  logic       line_valid,
  output logic [7:0] pix_s,
  output logic       fv_s,
  output logic       lv_s,
  output logic       cap
);

  logic clk_s;
  logic clk_prev;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      clk_s    <= 1'b0;
      clk_prev <= 1'b0;
      pix_s    <= '0;
      fv_s     <= 1'b0;
      lv_s     <= 1'b0;
    end else begin
      clk_s    <= clk_in;
      clk_prev <= clk_s;
      pix_s    <= pixel_in;
      fv_s     <= frame_valid;
      lv_s     <= line_valid;
    end
  end

  // The generator launches data on the rising edge of clk_in, so the falling
  // edge lands mid-period where the sampled bus is stable.
  assign cap = clk_prev & ~clk_s;

endmodule

// File: rtl/video_in_capture.sv
// Captures a pixel/frame_valid/line_valid video bus and packs 4 pixels per 32-bit word.
// Latency: w_en pulses 1 clk after the cap that completes (or flushes) a word.
// Backpressure: none upstream; a word offered while fifo_full=1 is dropped and overflow sticks.
//
// Optional build macro: VIDEO_IN_SIZE_CHECK_EN adds the sticky size_err output.
// Ports:
//   clk, nRST          system clock, async active-low reset
//   clk_in             video pixel clock (sampled as data)
//   pixel_in           8-bit pixel
//   frame_valid        high for the whole frame including line gaps
//   line_valid         high while a line's pixels are valid
//   fifo_full          downstream write FIFO full
//   w_en, w_data       one-clk write strobe and packed word (first pixel in [7:0])
//   frame_start        pulse when the first pixel of a frame is captured
//   frame_done         pulse when frame_valid falls after a frame with pixels
//   overflow           sticky: a word was dropped on fifo_full
//   size_err           (macro only) sticky: line length or line count mismatch
module video_in_capture
  import video_in_pkg::*;
#(
  parameter int p_WIDTH  = 640,
  parameter int p_HEIGHT = 480
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              clk_in,
  input  logic [7:0]        pixel_in,
  input  logic              frame_valid,
  input  logic              line_valid,
  input  logic              fifo_full,
  output logic              w_en,
  output logic [WORD_W-1:0] w_data,
  output logic              frame_start,
  output logic              frame_done,
  output logic              overflow
`ifdef VIDEO_IN_SIZE_CHECK_EN
  ,
  output logic              size_err
`endif
);

  localparam int SUB_W = $clog2(PIX_PER_WORD);
  localparam logic [SUB_W-1:0] LAST_LANE = SUB_W'(PIX_PER_WORD - 1);

  logic [7:0] pix_s;
  logic       fv_s;
  logic       lv_s;
  logic       cap;

  video_edge_sampler u_sampler (
    .clk         (clk),
    .nRST        (nRST),
    .clk_in      (clk_in),
    .pixel_in    (pixel_in),
    .frame_valid (frame_valid),
    .line_valid  (line_valid),
    .pix_s       (pix_s),
    .fv_s        (fv_s),
    .lv_s        (lv_s),
    .cap         (cap)
  );

  state_t state_q, state_d;

  logic [SUB_W-1:0]  sub_idx;
  logic [WORD_W-1:0] word_q;
  logic [9:0]        pix_cnt;
  logic [8:0]        line_cnt;
  logic              has_pix;   // at least one pixel captured in this frame

  logic take_pix;
  logic line_end;
  logic frame_end;
  logic store;
  logic wr_req;
  logic [WORD_W-1:0] wr_word;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state_q <= SYNC;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    take_pix  = 1'b0;
    line_end  = 1'b0;
    frame_end = 1'b0;
    if (cap) begin
      case (state_q)
        SYNC: begin
          // Never lock onto a frame already in progress.
          if (!fv_s) state_d = WAIT_FRAME;
        end
        WAIT_FRAME: begin
          if (fv_s) begin
            if (lv_s) begin
              take_pix = 1'b1;
              state_d  = LINE;
            end else begin
              state_d  = GAP;
            end
          end
        end
        LINE: begin
          if (!fv_s) begin
            // Frame dropped mid-line: close the line and the frame together.
            line_end  = 1'b1;
            frame_end = 1'b1;
            state_d   = WAIT_FRAME;
          end else if (!lv_s) begin
            line_end  = 1'b1;
            state_d   = GAP;
          end else begin
            take_pix  = 1'b1;
          end
        end
        GAP: begin
          if (!fv_s) begin
            frame_end = 1'b1;
            state_d   = WAIT_FRAME;
          end else if (lv_s) begin
            take_pix  = 1'b1;
            state_d   = LINE;
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

`ifdef VIDEO_IN_SIZE_CHECK_EN
  logic       over_width;
  logic [8:0] line_cnt_end;

  // Pixels past the expected width are discarded rather than packed.
  assign over_width   = (pix_cnt >= 10'(p_WIDTH));
  assign store        = take_pix & ~over_width;
  assign line_cnt_end = line_end ? (line_cnt + 9'd1) : line_cnt;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      size_err <= 1'b0;
    end else if ((take_pix && over_width) ||
                 (line_end && (pix_cnt != 10'(p_WIDTH))) ||
                 (frame_end && has_pix && (line_cnt_end != 9'(p_HEIGHT)))) begin
      size_err <= 1'b1;
    end
  end
`else
  assign store = take_pix;

  // Counters only feed the size checks; keep them referenced in this build.
  logic unused_cnt;
  assign unused_cnt = ^{pix_cnt, line_cnt, 10'(p_WIDTH), 9'(p_HEIGHT)};
`endif

  // A word leaves either when lane 3 fills or when a line ends part-way
  // through a word; unwritten lanes are already zero in word_q.
  assign wr_req  = (store && (sub_idx == LAST_LANE)) || (line_end && (sub_idx != '0));
  assign wr_word = store ? (word_q | (WORD_W'(pix_s) << {sub_idx, 3'b000})) : word_q;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      w_en        <= 1'b0;
      w_data      <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      word_q      <= '0;
      sub_idx     <= '0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      has_pix     <= 1'b0;
    end else begin
      w_en        <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;

      if (store) begin
        sub_idx     <= sub_idx + 1'b1;
        pix_cnt     <= pix_cnt + 10'd1;
        has_pix     <= 1'b1;
        frame_start <= ~has_pix;
      end

      if (wr_req) begin
        w_data   <= wr_word;
        w_en     <= ~fifo_full;
        overflow <= overflow | fifo_full;
        word_q   <= '0;
      end else if (store) begin
        word_q[{sub_idx, 3'b000} +: 8] <= pix_s;
      end

      if (line_end) begin
        sub_idx  <= '0;
        pix_cnt  <= '0;
        line_cnt <= line_cnt + 9'd1;
      end

      if (frame_end) begin
        line_cnt   <= '0;
        has_pix    <= 1'b0;
        frame_done <= has_pix;
      end
    end
  end

endmodule

// File: tb/tb_video_in_capture.sv
// Bench for video_in_capture: drives a video bus at 4 clk per pixel period,
// models expected words per line (4 pixels per word, zero-padded tail),
// and compares collected writes, frame pulses and overflow.
module tb_video_in_capture;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        clk_in = 1'b0;
  logic [7:0]  pixel_in = 8'h00;
  logic        frame_valid = 1'b0;
  logic        line_valid = 1'b0;
  logic        fifo_full = 1'b0;
  logic        w_en;
  logic [31:0] w_data;
  logic        frame_start;
  logic        frame_done;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          n_start = 0;
  int          n_done = 0;
  int          exp_start = 0;
  int          exp_done = 0;
  logic        exp_ovf = 1'b0;

  always #5 clk = ~clk;

  video_in_capture dut (
    .clk         (clk),
    .nRST        (nRST),
    .clk_in      (clk_in),
    .pixel_in    (pixel_in),
    .frame_valid (frame_valid),
    .line_valid  (line_valid),
    .fifo_full   (fifo_full),
    .w_en        (w_en),
    .w_data      (w_data),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  always @(negedge clk) begin
    if (w_en) got_q.push_back(w_data);
    if (frame_start) n_start++;
    if (frame_done) n_done++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One video period: data launched with clk_in rising, clk_in falls mid-period.
  task automatic vclk(input logic fv, input logic lv, input logic [7:0] px);
    @(negedge clk);
    clk_in = 1'b1;
    frame_valid = fv;
    line_valid = lv;
    pixel_in = px;
    @(negedge clk);
    @(negedge clk);
    clk_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_line(input int w, input bit full, input bit abrupt, input bit ramp);
    logic [7:0]  px[$];
    logic [7:0]  p;
    logic [31:0] wd;
    fifo_full = full;
    for (int i = 0; i < w; i++) begin
      p = ramp ? 8'(i) : 8'($urandom);
      px.push_back(p);
      vclk(1'b1, 1'b1, p);
    end
    // Two trailing periods so fifo_full is still held at the line-end cap.
    vclk(!abrupt, 1'b0, 8'h00);
    vclk(!abrupt, 1'b0, 8'h00);
    fifo_full = 1'b0;
    if (full) begin
      exp_ovf = 1'b1;
    end else begin
      for (int k = 0; k < w; k += 4) begin
        wd = '0;
        for (int j = 0; j < 4; j++)
          if (k + j < w) wd[8*j +: 8] = px[k + j];
        exp_q.push_back(wd);
      end
    end
  endtask

  task automatic send_frame(input int nl, input bit ramp, input int full_line);
    bit abrupt;
    int w;
    abrupt = ($urandom_range(0, 1) == 1);
    vclk(1'b1, 1'b0, 8'h00);
    vclk(1'b1, 1'b0, 8'h00);
    for (int l = 0; l < nl; l++) begin
      w = ramp ? $urandom_range(4, 20) : $urandom_range(1, 20);
      send_line(w, (l == full_line), abrupt && (l == nl - 1), ramp);
    end
    vclk(1'b0, 1'b0, 8'h00);
    vclk(1'b0, 1'b0, 8'h00);
    exp_start++;
    exp_done++;
  endtask

  task automatic compare_words(input string tag);
    int n;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_frame_state(input string tag);
    check({tag, "_starts"}, n_start, exp_start);
    check({tag, "_dones"}, n_done, exp_done);
    check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
  endtask

  initial begin
    // Reset with a frame already in progress on the bus.
    frame_valid = 1'b1;
    line_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_w_en", {31'd0, w_en}, 32'd0);
    check("rst_w_data", w_data, 32'd0);
    check("rst_frame_start", {31'd0, frame_start}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    nRST = 1'b1;

    // Tail of a frame already running: must be ignored entirely.
    for (int i = 0; i < 10; i++) vclk(1'b1, 1'b1, 8'(i + 1));
    vclk(1'b1, 1'b0, 8'h00);
    vclk(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) vclk(1'b1, 1'b1, 8'(i + 1));
    vclk(1'b1, 1'b0, 8'h00);
    repeat (3) vclk(1'b0, 1'b0, 8'h00);
    compare_words("midframe");
    check_frame_state("midframe");

    // Ramp frame: every line starts with pixels 0,1,2,3.
    send_frame(3, 1'b1, -1);
    check("ramp_first_word", (got_q.size() > 0) ? got_q[0] : 32'hdead_beef, 32'h0302_0100);
    compare_words("ramp");
    check_frame_state("ramp");

    // Random frames; frame 1 holds fifo_full over its second line.
    for (int f = 0; f < 4; f++) begin
      send_frame($urandom_range(2, 4), 1'b0, (f == 1) ? 1 : -1);
      compare_words($sformatf("rand%0d", f));
      check_frame_state($sformatf("rand%0d", f));
    end

    // Frame with no lines: no frame_done.
    repeat (3) vclk(1'b1, 1'b0, 8'h00);
    repeat (2) vclk(1'b0, 1'b0, 8'h00);
    compare_words("empty");
    check_frame_state("empty");

    // Reset mid-line with two pixels pending in the second word.
    vclk(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) vclk(1'b1, 1'b1, 8'(8'h11 + i));
    exp_q.push_back(32'h1413_1211);
    exp_start++;
    @(negedge clk);
    nRST = 1'b0;
    @(negedge clk);
    check("midline_rst_w_en", {31'd0, w_en}, 32'd0);
    check("midline_rst_w_data", w_data, 32'd0);
    check("midline_rst_frame_start", {31'd0, frame_start}, 32'd0);
    check("midline_rst_overflow", {31'd0, overflow}, 32'd0);
    exp_ovf = 1'b0;
    @(negedge clk);
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) vclk(1'b1, 1'b1, 8'(8'h21 + i));
    repeat (2) vclk(1'b1, 1'b0, 8'h00);
    repeat (2) vclk(1'b0, 1'b0, 8'h00);
    compare_words("midline_rst");
    check_frame_state("midline_rst");

    // Normal operation resumes after the reset.
    send_frame(3, 1'b0, -1);
    compare_words("after_rst");
    check_frame_state("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_in_capture.md
Name: video_in_capture

Overview:
- Receiver for the camera-style video bus (pixel / frame_valid / line_valid) driven by video_out_gen.
- Samples the bus in the system clock domain. The video clock is treated as data and edge-detected.
- Packs 4 pixels per 32-bit word and pushes the words into the downstream write FIFO.
- Reports frame boundaries and FIFO overflow.

Parameters:
- p_WIDTH, 640, expected pixels per line; must be a multiple of 4.
- p_HEIGHT, 480, expected lines per frame.

Ports:
- clk  input  1  system clock; all logic on posedge.
- nRST  input  1  asynchronous active-low reset.
- clk_in  input  1  video pixel clock; sampled as data, not used as a clock.
- pixel_in  input  8  video pixel.
- frame_valid  input  1  high for the whole frame, including inter-line gaps.
- line_valid  input  1  high while pixels of a line are valid.
- fifo_full  input  1  downstream FIFO full.
- w_en  output  1  one-clk write strobe.
- w_data  output  32  packed pixels; first pixel in [7:0], fourth in [31:24].
- frame_start  output  1  one-clk pulse when the first pixel of a frame is captured.
- frame_done  output  1  one-clk pulse when frame_valid falls after a captured frame.
- overflow  output  1  sticky; a word was dropped because the FIFO was full.

Behaviour:
- Interface: one clock (clk); reset nRST is asynchronous, active-low. All outputs and state clear on reset.
  - Reset values: w_en=0, w_data=0, frame_start=0, frame_done=0, overflow=0, size_err=0.
  - Reset mid-frame discards the partial word and counters, then re-enters SYNC.
- Input sampling:
  - clk_in, pixel_in, frame_valid and line_valid are registered once into a sample stage.
  - A second register holds the previous clk_in sample.
  - Capture strobe cap = previous clk_in 1 AND current sample 0, i.e. a falling edge, mid-period of the generator's data.
  - clk must be at least 4x the clk_in frequency. One cap per video period.
- Counters:
  - pix_cnt is 10 bits and counts pixels in the current line; it clears at line end.
  - line_cnt is 9 bits and counts completed lines; it clears at frame end.
  - sub_idx is 2 bits and gives the byte lane within the word.
- State machine. All transitions are evaluated only on cap cycles unless stated otherwise.
  - SYNC: entered after reset. Wait for sampled frame_valid=0, so the block never starts mid-frame. Then go to WAIT_FRAME.
  - WAIT_FRAME: on frame_valid=1 AND line_valid=1, capture the pixel, pulse frame_start, go to LINE. On frame_valid=1 AND line_valid=0, go to GAP.
  - LINE: each cap with line_valid=1 stores pixel_in into lane sub_idx and increments pix_cnt. On line_valid=0, line_cnt+1 and go to GAP. If frame_valid=0 is seen at the same time, treat it as line end plus frame end.
  - GAP: on line_valid=1, capture the pixel and go to LINE. On frame_valid=0, go to WAIT_FRAME and pulse frame_done. frame_done fires only if at least one pixel was captured in the frame.
- Packing and write:
  - When lane 3 is written, w_data is loaded and w_en pulses on the next clk. Capture-to-w_en latency is 1 clk.
  - If fifo_full=1 in that cycle, w_en stays 0, the word is dropped and overflow is set. overflow clears only on reset.
  - A line ending with sub_idx≠0 flushes a zero-padded word, with the same fifo_full rule.
- Simultaneous events: a flush write and the next line's first pixel cannot collide, because cap spacing is at least 4 clk.

Optional Feature:
- Macro: VIDEO_IN_SIZE_CHECK_EN.
- Defined: adds output size_err (1 bit, sticky, clears on reset only). It sets when:
  - a line ends with pix_cnt ≠ p_WIDTH; or
  - a line exceeds p_WIDTH pixels (extra pixels are dropped, not written); or
  - frame end occurs with line_cnt ≠ p_HEIGHT.
- Undefined: no size_err port and no checks. Line lengths are unconstrained except for the 10-bit pix_cnt wrap, which is harmless because pix_cnt is only used for checks.

Decomposition:
- Package video_in_pkg holds the state enum typedef {SYNC, WAIT_FRAME, LINE, GAP} and localparams PIX_PER_WORD=4 and WORD_W=32.
- One natural sub-module: video_edge_sampler. It provides the input registers, the falling-edge detect of clk_in, and the cap output.

Test Plan:
1. Drive video_out_gen with a 640x480 ramp, pixel = column mod 256 -> 76800 w_en pulses; first w_data of a line = 0x03020100; one frame_start and one frame_done; overflow=0.
2. Release reset while frame_valid=1 mid-frame -> no writes until frame_valid falls and rises; then a full frame of 76800 words.
3. Hold fifo_full=1 during line 10 -> the 160 words of that line are absent; overflow=1 and stays 1 through later frames; other lines intact.
4. Lines of 642 pixels (VIDEO_IN_SIZE_CHECK_EN defined) -> size_err=1 after line 0; the excess 2 pixels are not written (160 words per line).
5. Lines of 6 pixels (check disabled) -> per line one full word plus one flushed word 0x0000_0504-style zero-padded; no size_err port.
6. Assert nRST low during LINE with sub_idx=2 -> all outputs 0 within the reset; the partial word is never written.
